// File: rtl/mem_avmm_cmd_issuer_if.sv
// Avalon-MM master/slave bundle between the command issuer and the DDR controller.
//   avm_address / avm_read / avm_write / avm_writedata : command from the master
//   avm_waitrequest                                    : slave stall
//   avm_readdata / avm_readdatavalid                   : read response from the slave
interface mem_avmm_cmd_issuer_if #(
  parameter int unsigned AVM_ADDR_WIDTH = 27,
  parameter int unsigned WORD_WIDTH     = 64
);

  logic [AVM_ADDR_WIDTH-1:0] avm_address;
  logic                      avm_read;
  logic                      avm_write;
  logic [WORD_WIDTH-1:0]     avm_writedata;
  logic                      avm_waitrequest;
  logic [WORD_WIDTH-1:0]     avm_readdata;
  logic                      avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    output avm_write,
    output avm_writedata,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    input  avm_write,
    input  avm_writedata,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );

endinterface

// File: rtl/mem_avmm_cmd_issuer.sv
// Turns rowhammer state-machine requests into single Avalon-MM transactions, one at a time.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   gen_address/gen_word: request address / write data from the test state machine
//   write, state        : request direction; request is valid in test states 1..3
//   confirm             : 1-cycle pulse per completed (or timed-out) transaction
//   pattern_rb          : last word read back from memory
//   avm                 : Avalon-MM master port
//   busy                : high outside IDLE
//   rd_count/wr_count   : saturating completed-transaction counters
//   timeout_err         : sticky read-timeout flag
module mem_avmm_cmd_issuer #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned WORD_WIDTH     = 64,
  parameter int unsigned AVM_ADDR_WIDTH = 27,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_WIDTH-1:0]       gen_address,
  input  logic [WORD_WIDTH-1:0]       gen_word,
  input  logic                        write,
  input  logic [3:0]                  state,
  output logic                        confirm,
  output logic [WORD_WIDTH-1:0]       pattern_rb,
  mem_avmm_cmd_issuer_if.master       avm,
  output logic                        busy,
  output logic [31:0]                 rd_count,
  output logic [31:0]                 wr_count,
  output logic                        timeout_err
);

  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned CNT_W   = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RD,
    S_DONE
  } fsm_e;

  fsm_e                      fsm_q, fsm_d;
  logic                      wr_q, wr_d;
  logic [TMO_W-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic [AVM_ADDR_WIDTH-1:0] avm_address_q, avm_address_d;
  logic [WORD_WIDTH-1:0]     avm_writedata_q, avm_writedata_d;
  logic                      avm_read_q, avm_read_d;
  logic                      avm_write_q, avm_write_d;
  logic                      confirm_q, confirm_d;
  logic                      busy_q, busy_d;
  logic [WORD_WIDTH-1:0]     pattern_rb_q, pattern_rb_d;
  logic [CNT_W-1:0]          rd_count_q, rd_count_d;
  logic [CNT_W-1:0]          wr_count_q, wr_count_d;
  logic                      timeout_err_q, timeout_err_d;

  logic                      start_c;
  logic                      tmo_last_c;

  // Only the INIT, HAMMER and READ test states issue memory traffic.
  assign start_c    = (state == 4'd1) || (state == 4'd2) || (state == 4'd3);
  assign tmo_last_c = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Upper gen_address bits are outside the Avalon word address space.
  if (ADDR_WIDTH > AVM_ADDR_WIDTH) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^gen_address[ADDR_WIDTH-1:AVM_ADDR_WIDTH];
  end

  // Next-state and registered-output logic.
  always_comb begin
    fsm_d           = fsm_q;
    wr_d            = wr_q;
    tmo_cnt_d       = tmo_cnt_q;
    avm_address_d   = avm_address_q;
    avm_writedata_d = avm_writedata_q;
    avm_read_d      = avm_read_q;
    avm_write_d     = avm_write_q;
    pattern_rb_d    = pattern_rb_q;
    rd_count_d      = rd_count_q;
    wr_count_d      = wr_count_q;
    timeout_err_d   = timeout_err_q;
    confirm_d       = 1'b0;
    busy_d          = 1'b0;

    unique case (fsm_q)
      S_IDLE: begin
        if (start_c) begin
          // Latch the request; later changes upstream are ignored until DONE.
          avm_address_d   = gen_address[AVM_ADDR_WIDTH-1:0];
          avm_writedata_d = gen_word;
          wr_d            = write;
          avm_write_d     = write;
          avm_read_d      = ~write;
          fsm_d           = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (!avm.avm_waitrequest) begin
          avm_read_d  = 1'b0;
          avm_write_d = 1'b0;
          if (wr_q) begin
            wr_count_d = (wr_count_q == '1) ? wr_count_q : wr_count_q + CNT_W'(1);
            fsm_d      = S_DONE;
          end else begin
            tmo_cnt_d = '0;
            fsm_d     = S_WAIT_RD;
          end
        end
      end

      S_WAIT_RD: begin
        // Data in the same cycle as the last timeout count still counts as a good read.
        if (avm.avm_readdatavalid) begin
          pattern_rb_d = avm.avm_readdata;
          rd_count_d   = (rd_count_q == '1) ? rd_count_q : rd_count_q + CNT_W'(1);
          fsm_d        = S_DONE;
        end else if (tmo_last_c) begin
          timeout_err_d = 1'b1;
          fsm_d         = S_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      S_DONE: begin
        fsm_d = S_IDLE;
      end

      default: begin
        fsm_d = S_IDLE;
      end
    endcase

    confirm_d = (fsm_d == S_DONE);
    busy_d    = (fsm_d != S_IDLE);
  end

  // State register; reset aborts any in-flight command without reissue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q           <= S_IDLE;
      wr_q            <= 1'b0;
      tmo_cnt_q       <= '0;
      avm_address_q   <= '0;
      avm_writedata_q <= '0;
      avm_read_q      <= 1'b0;
      avm_write_q     <= 1'b0;
      confirm_q       <= 1'b0;
      busy_q          <= 1'b0;
      pattern_rb_q    <= '0;
      rd_count_q      <= '0;
      wr_count_q      <= '0;
      timeout_err_q   <= 1'b0;
    end else begin
      fsm_q           <= fsm_d;
      wr_q            <= wr_d;
      tmo_cnt_q       <= tmo_cnt_d;
      avm_address_q   <= avm_address_d;
      avm_writedata_q <= avm_writedata_d;
      avm_read_q      <= avm_read_d;
      avm_write_q     <= avm_write_d;
      confirm_q       <= confirm_d;
      busy_q          <= busy_d;
      pattern_rb_q    <= pattern_rb_d;
      rd_count_q      <= rd_count_d;
      wr_count_q      <= wr_count_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  assign avm.avm_address   = avm_address_q;
  assign avm.avm_writedata = avm_writedata_q;
  assign avm.avm_read      = avm_read_q;
  assign avm.avm_write     = avm_write_q;
  assign confirm           = confirm_q;
  assign busy              = busy_q;
  assign pattern_rb        = pattern_rb_q;
  assign rd_count          = rd_count_q;
  assign wr_count          = wr_count_q;
  assign timeout_err       = timeout_err_q;

endmodule

// File: tb/tb_mem_avmm_cmd_issuer.sv
// Scoreboard bench for mem_avmm_cmd_issuer with a small Avalon slave model.
module tb_mem_avmm_cmd_issuer;

  localparam int unsigned ADDR_WIDTH     = 64;
  localparam int unsigned WORD_WIDTH     = 64;
  localparam int unsigned AVM_ADDR_WIDTH = 27;
  localparam int unsigned TIMEOUT_CYCLES = 16;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [ADDR_WIDTH-1:0] gen_address;
  logic [WORD_WIDTH-1:0] gen_word;
  logic                  write;
  logic [3:0]            state;
  logic                  confirm;
  logic [WORD_WIDTH-1:0] pattern_rb;
  logic                  busy;
  logic [31:0]           rd_count;
  logic [31:0]           wr_count;
  logic                  timeout_err;

  mem_avmm_cmd_issuer_if #(.AVM_ADDR_WIDTH(AVM_ADDR_WIDTH), .WORD_WIDTH(WORD_WIDTH)) avm_bus ();

  mem_avmm_cmd_issuer #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .WORD_WIDTH    (WORD_WIDTH),
    .AVM_ADDR_WIDTH(AVM_ADDR_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .gen_address(gen_address),
    .gen_word   (gen_word),
    .write      (write),
    .state      (state),
    .confirm    (confirm),
    .pattern_rb (pattern_rb),
    .avm        (avm_bus.master),
    .busy       (busy),
    .rd_count   (rd_count),
    .wr_count   (wr_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                      wr;
    logic [AVM_ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0]     wdata;
    logic [WORD_WIDTH-1:0]     rdata;
    bit                        tmo;
    int                        strobe_cyc;
    int                        lat;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Slave behaviour for the current transaction.
  int                    g_wait   = 0;
  int                    g_lat    = 1;
  logic [WORD_WIDTH-1:0] g_rdata  = '0;
  bit                    g_nodata = 1'b0;
  bit                    g_late   = 1'b0;

  // Avalon slave model: stalls g_wait cycles, returns read data g_lat cycles after accept.
  initial begin
    int  stall_left;
    int  lat_left;
    bit  in_cmd;
    stall_left = 0;
    lat_left   = 0;
    in_cmd     = 1'b0;
    avm_bus.avm_waitrequest   = 1'b0;
    avm_bus.avm_readdatavalid = 1'b0;
    avm_bus.avm_readdata      = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_cmd   = 1'b0;
        lat_left = 0;
        avm_bus.avm_waitrequest   = 1'b0;
        avm_bus.avm_readdatavalid = 1'b0;
      end else begin
        avm_bus.avm_readdatavalid = 1'b0;
        avm_bus.avm_readdata      = {$urandom, $urandom};
        if (lat_left > 0) begin
          lat_left--;
          if (lat_left == 0 && !g_nodata) begin
            avm_bus.avm_readdatavalid = 1'b1;
            avm_bus.avm_readdata      = g_rdata;
          end
        end
        if (g_late) begin
          g_late = 1'b0;
          avm_bus.avm_readdatavalid = 1'b1;
          avm_bus.avm_readdata      = 64'hDEAD_BEEF_0BAD_F00D;
        end
        if (avm_bus.avm_read || avm_bus.avm_write) begin
          if (!in_cmd) begin
            in_cmd     = 1'b1;
            stall_left = g_wait;
          end
          if (stall_left > 0) begin
            avm_bus.avm_waitrequest = 1'b1;
            stall_left--;
          end else begin
            avm_bus.avm_waitrequest = 1'b0;
            in_cmd = 1'b0;
            if (avm_bus.avm_read) lat_left = g_lat;
          end
        end else begin
          avm_bus.avm_waitrequest = 1'b0;
        end
      end
    end
  end

  // Reference model state, advanced when a transaction is confirmed.
  logic [WORD_WIDTH-1:0] exp_rb  = '0;
  logic [31:0]           exp_rd  = '0;
  logic [31:0]           exp_wr  = '0;
  logic                  exp_tmo = 1'b0;
  int                    stray   = 0;
  int                    n_conf  = 0;

  // Monitor: checks commands against the queue head and pops on confirm.
  initial begin
    bit   active;
    int   age;
    int   strobe_cyc;
    exp_t e;
    active     = 1'b0;
    age        = 0;
    strobe_cyc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 1'b0;
      end else begin
        if (active) age++;
        if (avm_bus.avm_read || avm_bus.avm_write) begin
          if (!active) begin
            if (sb_q.size() == 0) begin
              stray++;
            end else begin
              active     = 1'b1;
              age        = 0;
              strobe_cyc = 0;
            end
          end
          if (active) begin
            strobe_cyc++;
            check_eq("strobe_kind", 64'({avm_bus.avm_write, avm_bus.avm_read}),
                     64'({sb_q[0].wr, ~sb_q[0].wr}));
            check_eq("avm_address", 64'(avm_bus.avm_address), 64'(sb_q[0].addr));
            if (sb_q[0].wr) check_eq("avm_writedata", avm_bus.avm_writedata, sb_q[0].wdata);
          end
        end
        if (confirm) begin
          if (!active || sb_q.size() == 0) begin
            check_eq("spurious_confirm", 64'(confirm), 64'(0));
          end else begin
            e      = sb_q.pop_front();
            active = 1'b0;
            n_conf++;
            if (e.wr) begin
              exp_wr = sat_inc(exp_wr);
            end else if (e.tmo) begin
              exp_tmo = 1'b1;
            end else begin
              exp_rb = e.rdata;
              exp_rd = sat_inc(exp_rd);
            end
            check_eq("confirm_latency", 64'(age), 64'(e.lat));
            check_eq("strobe_cycles", 64'(strobe_cyc), 64'(e.strobe_cyc));
            check_eq("pattern_rb", pattern_rb, exp_rb);
            check_eq("rd_count", 64'(rd_count), 64'(exp_rd));
            check_eq("wr_count", 64'(wr_count), 64'(exp_wr));
            check_eq("timeout_err", 64'(timeout_err), 64'(exp_tmo));
            check_eq("busy_done", 64'(busy), 64'(1));
          end
        end
      end
    end
  end

  // Push the expected outcome, present the request, wait for confirm, then withdraw.
  task automatic do_req(input logic [3:0] st, input logic wr, input logic [63:0] addr,
                        input logic [63:0] word, input logic [63:0] rdata,
                        input int wt, input int lat, input bit nodata);
    exp_t e;
    int   budget;
    e.wr         = wr;
    e.addr       = addr[AVM_ADDR_WIDTH-1:0];
    e.wdata      = word;
    e.rdata      = rdata;
    e.tmo        = !wr && nodata;
    e.strobe_cyc = wt + 1;
    e.lat        = wr ? wt + 1 : (nodata ? wt + 1 + int'(TIMEOUT_CYCLES) : wt + lat + 1);
    g_wait   = wt;
    g_lat    = lat;
    g_rdata  = rdata;
    g_nodata = nodata;
    sb_q.push_back(e);
    gen_address = addr;
    gen_word    = word;
    write       = wr;
    state       = st;
    budget      = 0;
    do begin
      @(negedge clk);
      budget++;
      // Scramble the request while the command is on the bus; the latched copy must hold.
      if (avm_bus.avm_read || avm_bus.avm_write) begin
        gen_address = {$urandom, $urandom};
        gen_word    = {$urandom, $urandom};
      end
    end while (!confirm && budget < 200);
    if (!confirm) begin
      check_eq("confirm_timeout", 64'(confirm), 64'(1));
      sb_q.delete();
    end
    state       = 4'd0;
    write       = ~wr;
    gen_address = {$urandom, $urandom};
    gen_word    = {$urandom, $urandom};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          conf_base;
    logic [31:0] rd_base;
    int          budget;
    exp_t        e;
    reset       = 1'b1;
    gen_address = '0;
    gen_word    = '0;
    write       = 1'b0;
    state       = 4'd0;
    repeat (3) @(negedge clk);

    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_confirm", 64'(confirm), 64'(0));
    check_eq("rst_strobes", 64'({avm_bus.avm_read, avm_bus.avm_write}), 64'(0));
    check_eq("rst_address", 64'(avm_bus.avm_address), 64'(0));
    check_eq("rst_writedata", avm_bus.avm_writedata, 64'(0));
    check_eq("rst_pattern_rb", pattern_rb, 64'(0));
    check_eq("rst_counts", {rd_count, wr_count}, 64'(0));
    check_eq("rst_timeout_err", 64'(timeout_err), 64'(0));

    reset = 1'b0;
    @(negedge clk);

    // Non-test states never start a transaction.
    begin
      logic [3:0] idle_states [4];
      idle_states = '{4'd0, 4'd4, 4'd5, 4'd15};
      for (int i = 0; i < 4; i++) begin
        state = idle_states[i];
        write = i[0];
        repeat (4) @(negedge clk);
        check_eq("idle_busy", 64'(busy), 64'(0));
      end
      state = 4'd0;
    end
    check_eq("idle_stray", 64'(stray), 64'(0));

    // INIT write, no stall.
    do_req(4'd1, 1'b1, 64'h400, {8{8'hA5}}, '0, 0, 1, 1'b0);
    // READ with 3-cycle stall, data 5 cycles after accept.
    do_req(4'd3, 1'b0, 64'h0123_4567_0000_0800, '0, {8{8'h5A}}, 3, 5, 1'b0);
    // Stalled write.
    do_req(4'd2, 1'b1, 64'h7FF_FFFF, 64'h1122_3344_5566_7788, '0, 2, 1, 1'b0);

    // Read timeout, then a late valid that must be ignored.
    do_req(4'd3, 1'b0, 64'h55, '0, 64'hCAFE, 1, 1, 1'b1);
    g_late = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("late_pattern_rb", pattern_rb, exp_rb);
    check_eq("late_rd_count", 64'(rd_count), 64'(exp_rd));
    check_eq("late_timeout_err", 64'(timeout_err), 64'(1));
    g_nodata = 1'b0;

    // Mixed random traffic.
    for (int i = 0; i < 12; i++) begin
      do_req(4'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
             {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), 1'b0);
    end

    // Hammer loop: 100 reads with 1-cycle latency.
    conf_base = n_conf;
    rd_base   = exp_rd;
    for (int i = 0; i < 100; i++) begin
      do_req(4'd2, 1'b0, 64'(i * 64), '0, {$urandom, $urandom}, 0, 1, 1'b0);
    end
    check_eq("hammer_confirms", 64'(n_conf - conf_base), 64'(100));
    check_eq("hammer_rd_count", 64'(rd_count), 64'(rd_base + 32'd100));

    // Reset while stalled in ISSUE.
    g_wait = 1000;
    e.wr = 1'b1; e.addr = 27'h321; e.wdata = 64'h99; e.rdata = '0;
    e.tmo = 1'b0; e.strobe_cyc = 0; e.lat = 0;
    sb_q.push_back(e);
    gen_address = 64'h321;
    gen_word    = 64'h99;
    write       = 1'b1;
    state       = 4'd1;
    budget      = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!avm_bus.avm_write && budget < 20);
    check_eq("pre_reset_strobe", 64'(avm_bus.avm_write), 64'(1));
    #2 reset = 1'b1;
    #1;
    check_eq("mid_reset_strobes", 64'({avm_bus.avm_read, avm_bus.avm_write}), 64'(0));
    check_eq("mid_reset_busy", 64'(busy), 64'(0));
    check_eq("mid_reset_counts", {rd_count, wr_count}, 64'(0));
    check_eq("mid_reset_timeout_err", 64'(timeout_err), 64'(0));
    sb_q.delete();
    exp_rb  = '0;
    exp_rd  = '0;
    exp_wr  = '0;
    exp_tmo = 1'b0;
    state   = 4'd0;
    g_wait  = 0;
    stray   = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("post_reset_stray", 64'(stray), 64'(0));
    check_eq("post_reset_busy", 64'(busy), 64'(0));

    // Write counter saturation from a preloaded value.
    force dut.wr_count_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.wr_count_q;
    exp_wr = 32'hFFFF_FFFE;
    do_req(4'd1, 1'b1, 64'h10, 64'h1, '0, 0, 1, 1'b0);
    do_req(4'd1, 1'b1, 64'h11, 64'h2, '0, 1, 1, 1'b0);
    check_eq("sat_wr_count", 64'(wr_count), 64'(32'hFFFF_FFFF));

    repeat (3) @(negedge clk);
    check_eq("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
